capture_controller: RTL

- Capture sequencer for the logic analyzer; sits directly upstream of sample_counter.
- Drives the counter's en_cnt/clr_cnt and consumes its delay_match/read_match.
- Writes samples into a circular sample RAM until trigger plus post-trigger delay, then streams the last read_len samples out through a valid/ready port.

---
 rtl/capture_pkg.sv | 13 +
 rtl/capture_readback.sv | 46 ++++
 rtl/capture_controller.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/capture_pkg.sv
// Shared types for the logic-analyzer capture sequencer.
package capture_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ARMED    = 3'd1,
        ST_DELAY    = 3'd2,
        ST_RD_SETUP = 3'd3,
        ST_READBACK = 3'd4,
        ST_DONE     = 3'd5
    } cap_state_t;

endpackage

// File: rtl/capture_readback.sv
// Readback stage: one RAM read in flight and a registered
// valid/ready output word.
module capture_readback #(
    parameter int SAMPLE_BITS = 32
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   i_issue,
    input  logic                   i_abort,
    input  logic [SAMPLE_BITS-1:0] i_rd_data,
    input  logic                   i_out_ready,
    output logic                   o_slot_free,
    output logic                   o_out_valid,
    output logic [SAMPLE_BITS-1:0] o_out_data
);

    logic                   r_rd_pending;
    logic                   r_out_valid;
    logic [SAMPLE_BITS-1:0] r_out_data;

    assign o_slot_free = !r_rd_pending && (!r_out_valid || i_out_ready);
    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;

    // A read is only issued when the output slot frees this cycle,
    // so the load never overwrites an unaccepted word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_pending <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
        end else if (i_abort) begin
            r_rd_pending <= 1'b0;
            r_out_valid  <= 1'b0;
        end else begin
            r_rd_pending <= i_issue;
            if (r_rd_pending) begin
                r_out_valid <= 1'b1;
                r_out_data  <= i_rd_data;
            end else if (i_out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/capture_controller.sv
// Capture sequencer: circular sample writes until trigger plus
// post-trigger delay, then streams the last read_len samples out.
module capture_controller
    import capture_pkg::*;
#(
    parameter int CNT_BITS    = 16,
    parameter int ADDR_BITS   = 12,
    parameter int SAMPLE_BITS = 32
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   arm,
    input  logic                   abort,
    input  logic                   sample_valid,
    input  logic                   trigger,
    input  logic [CNT_BITS-1:0]    read_len,
    input  logic                   delay_match,
    input  logic                   read_match,
    output logic                   en_cnt,
    output logic                   clr_cnt,
    output logic                   mem_wr_en,
    output logic [ADDR_BITS-1:0]   mem_wr_addr,
    output logic                   mem_rd_en,
    output logic [ADDR_BITS-1:0]   mem_rd_addr,
    input  logic [SAMPLE_BITS-1:0] mem_rd_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [SAMPLE_BITS-1:0] out_data,
    output logic                   busy,
    output logic                   done,
    output logic [ADDR_BITS-1:0]   trig_addr
);

    cap_state_t             r_state;
    cap_state_t             w_next;
    logic [ADDR_BITS-1:0]   r_wr_addr;
    logic [ADDR_BITS-1:0]   r_rd_addr;
    logic [ADDR_BITS-1:0]   r_trig_addr;
    logic                   w_en;
    logic                   w_clr;
    logic                   w_wr;
    logic                   w_trig;
    logic                   w_setup;
    logic                   w_issue;
    logic                   w_slot_free;

    always_comb begin
        w_next  = r_state;
        w_en    = 1'b0;
        w_clr   = 1'b0;
        w_wr    = 1'b0;
        w_trig  = 1'b0;
        w_setup = 1'b0;
        w_issue = 1'b0;
        if (abort) begin
            w_next = ST_IDLE;
        end else begin
            unique case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (arm) begin
                        w_next = ST_ARMED;
                        w_clr  = 1'b1;
                    end
                end
                ST_ARMED: begin
                    if (sample_valid) begin
                        w_wr = 1'b1;
                        if (trigger) begin
                            w_trig = 1'b1;
                            w_clr  = 1'b1;
                            w_next = ST_DELAY;
                        end
                    end
                end
                ST_DELAY: begin
                    if (delay_match) begin
                        w_next = ST_RD_SETUP;
                    end else if (sample_valid) begin
                        w_wr = 1'b1;
                        w_en = 1'b1;
                    end
                end
                ST_RD_SETUP: begin
                    w_setup = 1'b1;
                    w_clr   = 1'b1;
                    w_next  = ST_READBACK;
                end
                ST_READBACK: begin
                    if (w_slot_free) begin
                        if (read_match) begin
                            w_next = ST_DONE;
                        end else begin
                            w_issue = 1'b1;
                            w_en    = 1'b1;
                        end
                    end
                end
                default: w_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_wr_addr   <= '0;
            r_rd_addr   <= '0;
            r_trig_addr <= '0;
        end else begin
            r_state <= w_next;
            if (w_wr) r_wr_addr <= r_wr_addr + 1'b1;
            if (w_trig) r_trig_addr <= r_wr_addr;
            // Oldest of the last read_len samples; wraps mod depth.
            if (w_setup) r_rd_addr <= r_wr_addr - ADDR_BITS'(read_len);
            if (w_issue) r_rd_addr <= r_rd_addr + 1'b1;
        end
    end

    capture_readback #(
        .SAMPLE_BITS(SAMPLE_BITS)
    ) u_readback (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_issue    (w_issue),
        .i_abort    (abort),
        .i_rd_data  (mem_rd_data),
        .i_out_ready(out_ready),
        .o_slot_free(w_slot_free),
        .o_out_valid(out_valid),
        .o_out_data (out_data)
    );

    // Strobes are gated so they read 0 the instant reset asserts.
    assign en_cnt      = w_en && reset_n;
    assign clr_cnt     = w_clr && reset_n;
    assign mem_wr_en   = w_wr && reset_n;
    assign mem_rd_en   = w_issue && reset_n;
    assign mem_wr_addr = r_wr_addr;
    assign mem_rd_addr = r_rd_addr;
    assign trig_addr   = r_trig_addr;
    assign busy        = (r_state != ST_IDLE) && (r_state != ST_DONE);
    assign done        = (r_state == ST_DONE);

endmodule
